// File: rtl/pmod_uart_pkg.sv
// Shared constants, state encoding and helpers for the PMOD UART receive and transmit paths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pmod_uart_pkg;

    localparam int unsigned OS_RATE    = 16;
    localparam logic [3:0]  SAMPLE_LO  = 4'd7;
    localparam logic [3:0]  SAMPLE_MID = 4'd8;
    localparam logic [3:0]  SAMPLE_HI  = 4'd9;
    localparam logic [3:0]  SC_LAST    = 4'(OS_RATE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_os_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud * (OS_RATE / 2)) / (baud * OS_RATE);
    endfunction

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pmod_uart_rx_if.sv
// Received-byte stream: data/valid from the receiver, ready from the consumer.
// Latency: n/a (wires only).
// Backpressure: byte transfers when m_valid and m_ready are both high.
interface pmod_uart_rx_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/pmod_uart_rx_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Latency: push visible at head one cycle later; pop_dat is the combinational head.
// Backpressure: push while full is dropped unless a pop frees the slot in the same cycle.
module pmod_uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    // Empty head reads as zero so the output is defined out of reset.
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/pmod_uart_rx.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote, feeding a byte FIFO.
// Latency: m_valid rises one cycle after the stop-bit decision (sc=9 tick of the stop bit).
// Backpressure: m_ready pops the FIFO; bytes arriving while full are dropped and flag overrun.
module pmod_uart_rx
    import pmod_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int OS_DIV      = calc_os_div(CLK_FREQ_HZ, BAUD),
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          sys_clock,
    input  logic                          reset,
    input  logic                          pmod_uart_rxd,
    pmod_uart_rx_if.master                m_if,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       sc_q, sc_d;
    logic [1:0]       samp_q, samp_d;
    logic             bit_q, bit_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic rxs, tick, vote, push, fe_set, ovr_set, pop, fifo_full, fifo_empty;

    assign rxs  = sync_q[1];
    assign tick = (div_q == DIV_LAST);
    // Third sample is the live synchronized value at the sc=9 tick.
    assign vote = maj3(samp_q[0], samp_q[1], rxs);

    // Receiver next-state: tick divider, sample capture, framing FSM, sticky errors.
    always_comb begin
        sync_d      = {sync_q[0], pmod_uart_rxd};
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        sc_d        = sc_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        push        = 1'b0;
        fe_set      = 1'b0;

        if (tick && sc_q == SAMPLE_LO)  samp_d[0] = rxs;
        if (tick && sc_q == SAMPLE_MID) samp_d[1] = rxs;
        if (tick && sc_q == SAMPLE_HI)  bit_d     = vote;
        if (tick && state_q != IDLE)    sc_d      = sc_q + 4'd1;

        case (state_q)
            IDLE: begin
                // After a break the line must read high on a tick before re-arming.
                if (tick && rxs) armed_d = 1'b1;
                if (!rxs && armed_q) begin
                    state_d = START;
                    div_d   = '0;
                    sc_d    = '0;
                end
            end
            START: begin
                if (tick && sc_q == SC_LAST) begin
                    state_d = bit_q ? IDLE : DATA;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (tick && sc_q == SC_LAST) begin
                    shift_d = {bit_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Decide mid-stop-bit so a back-to-back start edge is not missed.
                if (tick && sc_q == SAMPLE_HI) begin
                    state_d = IDLE;
                    if (vote) begin
                        push = 1'b1;
                    end else begin
                        fe_set  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        frame_err_d = fe_set  ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
        overrun_d   = ovr_set ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
    end

    // Receiver state registers.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            div_q       <= '0;
            sc_q        <= '0;
            samp_q      <= 2'b11;
            bit_q       <= 1'b1;
            bcnt_q      <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            div_q       <= div_d;
            sc_q        <= sc_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pop          = ~fifo_empty & m_if.m_ready;
    assign ovr_set      = push & fifo_full & ~pop;
    assign m_if.m_valid = ~fifo_empty;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

    pmod_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (sys_clock),
        .rst      (reset),
        .push     (push),
        .push_dat (shift_q),
        .pop      (pop),
        .pop_dat  (m_if.m_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_pmod_uart_rx.sv
// Directed bench for the PMOD UART receiver using a fast baud so each bit is 128 clocks.
// Latency: n/a.
// Backpressure: consumer ready is driven per step.
module tb_pmod_uart_rx;
    localparam int BIT = 128;   // OS_DIV=8 at 100 MHz / 781250 baud

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       err_clear;
    logic       frame_err;
    logic       overrun;
    logic [4:0] fifo_level;

    int checks   = 0;
    int failures = 0;
    int max_level = 0;
    logic [7:0] rx_q[$];

    pmod_uart_rx_if bus();

    pmod_uart_rx #(
        .CLK_FREQ_HZ (100000000),
        .BAUD        (781250),
        .FIFO_DEPTH  (16)
    ) dut (
        .sys_clock     (clk),
        .reset         (rst),
        .pmod_uart_rxd (rxd),
        .m_if          (bus),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .err_clear     (err_clear),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    // Record every accepted beat and the peak occupancy, sampled mid-cycle.
    always @(negedge clk) begin
        #1;
        if (!rst && bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            idle(bit_clks);
        end
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        bus.m_ready = 1'b1;
        idle(1);
        bus.m_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
    endtask

    initial begin
        logic [9:0] partial;
        rst = 1'b1; rxd = 1'b1; err_clear = 1'b0; bus.m_ready = 1'b0;
        idle(5);
        check("rst_m_valid",    bus.m_valid, 0);
        check("rst_m_data",     bus.m_data,  0);
        check("rst_frame_err",  frame_err,   0);
        check("rst_overrun",    overrun,     0);
        check("rst_fifo_level", fifo_level,  0);
        rst = 1'b0;
        idle(4 * BIT);

        // Single byte, held in FIFO until popped.
        send_byte(8'hA5, BIT, 1'b1);
        check("a5_valid", bus.m_valid, 1);
        check("a5_data",  bus.m_data,  8'hA5);
        check("a5_ferr",  frame_err,   0);
        check("a5_level", fifo_level,  1);
        rx_q.delete();
        pop_one();
        idle(4);
        check("a5_popcnt", rx_q.size(), 1);
        check("a5_popdat", rx_q[0], 8'hA5);
        check("a5_empty",  bus.m_valid, 0);

        // Back-to-back bytes with consumer always ready.
        rx_q.delete(); max_level = 0; bus.m_ready = 1'b1;
        send_byte(8'h00, BIT, 1'b1);
        send_byte(8'hFF, BIT, 1'b1);
        send_byte(8'h55, BIT, 1'b1);
        idle(2 * BIT);
        check("b2b_count", rx_q.size(), 3);
        check("b2b_0", rx_q[0], 8'h00);
        check("b2b_1", rx_q[1], 8'hFF);
        check("b2b_2", rx_q[2], 8'h55);
        check("b2b_maxlvl", max_level, 1);

        // Short low glitch on idle line is rejected silently.
        rx_q.delete();
        rxd = 1'b0; idle(40); rxd = 1'b1;
        idle(3 * BIT);
        check("glitch_count", rx_q.size(), 0);
        check("glitch_ferr",  frame_err,   0);

        // Stop bit low: framing error, byte dropped, then cleared.
        send_byte(8'h3C, BIT, 1'b0);
        idle(2 * BIT);
        check("fe_set",   frame_err,   1);
        check("fe_count", rx_q.size(), 0);
        pulse_clear();
        idle(2);
        check("fe_clear", frame_err, 0);

        // Break: flagged once, no re-trigger while the line stays low.
        rxd = 1'b0;
        idle(10 * BIT);
        check("brk_first", frame_err, 1);
        pulse_clear();
        idle(12 * BIT);
        check("brk_once",  frame_err,   0);
        check("brk_count", rx_q.size(), 0);
        rxd = 1'b1;
        idle(3 * BIT);
        send_byte(8'h5A, BIT, 1'b1);
        idle(2 * BIT);
        check("brk_after_cnt", rx_q.size(), 1);
        check("brk_after_dat", rx_q[0], 8'h5A);

        // Fill past capacity with consumer stalled.
        bus.m_ready = 1'b0; rx_q.delete();
        for (int i = 1; i <= 17; i++) send_byte(8'(i), BIT, 1'b1);
        idle(BIT);
        check("ovr_level", fifo_level, 16);
        check("ovr_flag",  overrun,    1);
        check("ovr_head",  bus.m_data, 8'h01);
        bus.m_ready = 1'b1;
        idle(40);
        bus.m_ready = 1'b0;
        check("ovr_drain_cnt", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) check($sformatf("ovr_drain_%0d", i), rx_q[i], 8'(i + 1));
        check("ovr_drained", fifo_level, 0);
        pulse_clear();
        idle(2);
        check("ovr_clear", overrun, 0);

        // Reset in the middle of bit 4 of 0x96 with one byte already queued.
        send_byte(8'h77, BIT, 1'b1);
        idle(BIT);
        check("mid_pre_level", fifo_level, 1);
        partial = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxd = partial[i];
            idle(BIT);
        end
        rxd = partial[5];
        idle(BIT / 2);
        rst = 1'b1;
        idle(3);
        check("mid_rst_valid", bus.m_valid, 0);
        check("mid_rst_data",  bus.m_data,  0);
        check("mid_rst_level", fifo_level,  0);
        check("mid_rst_ferr",  frame_err,   0);
        check("mid_rst_ovr",   overrun,     0);
        rxd = 1'b1;
        idle(BIT);
        rst = 1'b0;
        idle(2 * BIT);
        send_byte(8'h42, BIT, 1'b1);
        idle(BIT);
        check("mid_after_level", fifo_level, 1);
        check("mid_after_data",  bus.m_data, 8'h42);
        check("mid_after_ferr",  frame_err,  0);
        rx_q.delete();
        pop_one();
        idle(2 * BIT);

        // Baud skew of +/-3%.
        bus.m_ready = 1'b1;
        send_byte(8'hC3, 124, 1'b1);
        idle(2 * BIT);
        send_byte(8'h81, 132, 1'b1);
        idle(2 * BIT);
        check("skew_count", rx_q.size(), 3);
        check("skew_42",    rx_q[0], 8'h42);
        check("skew_fast",  rx_q[1], 8'hC3);
        check("skew_slow",  rx_q[2], 8'h81);
        check("skew_ferr",  frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
